// File: rtl/rng_pkg.sv
// Shared types and default coefficients for the linear congruential random generator.
package rng_pkg;

   typedef logic [31:0] rng_word_t;

   // Numerical Recipes coefficients; the increment is odd, giving full 2^32 period.
   localparam rng_word_t LCG_MULT_DEFAULT = 32'd1664525;
   localparam rng_word_t LCG_INC_DEFAULT  = 32'd1013904223;

endpackage : rng_pkg

// File: rtl/lcg_step.sv
// Combinational single LCG step: next = state*MULT + INC, truncated to 32 bits.
module lcg_step
   import rng_pkg::*;
#(
   parameter rng_word_t MULT = LCG_MULT_DEFAULT,
   parameter rng_word_t INC  = LCG_INC_DEFAULT
) (
   input  rng_word_t state_i,
   output rng_word_t next_o
);

   rng_word_t product_s;

   // Only the low word of the product and sum is kept, so both wrap mod 2^32.
   always_comb begin
      product_s = state_i * MULT;
      next_o    = product_s + INC;
   end

endmodule : lcg_step

// File: rtl/linear_rng_gen.sv
// 32-bit LCG random source: registered state, async reset, synchronous reseed.
module linear_rng_gen
   import rng_pkg::*;
#(
   parameter rng_word_t MULT       = LCG_MULT_DEFAULT,
   parameter rng_word_t INC        = LCG_INC_DEFAULT,
   parameter rng_word_t RESET_SEED = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] initialSeed,
   input  logic        loadSeed,
   output logic [31:0] random
);

   rng_word_t state_q;
   rng_word_t state_d;
   rng_word_t step_s;

   lcg_step #(
      .MULT (MULT),
      .INC  (INC)
   ) u_lcg_step (
      .state_i (state_q),
      .next_o  (step_s)
   );

   // Reseed has priority over the step; the step is suppressed on a load edge.
   always_comb begin
      state_d = state_q;
      if (loadSeed == 1'b1) begin
         state_d = initialSeed;
      end else begin
         state_d = step_s;
      end
   end

   // State register, forced to the reset seed asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign random = state_q;

endmodule : linear_rng_gen

// File: tb/tb_linear_rng_gen.sv
// Directed self-checking bench for linear_rng_gen using hand-computed LCG values.
module tb_linear_rng_gen;

   logic        clock;
   logic        reset;
   logic [31:0] initialSeed;
   logic        loadSeed;
   logic [31:0] random;

   int n_cmp  = 0;
   int n_fail = 0;

   linear_rng_gen dut (
      .clock       (clock),
      .reset       (reset),
      .initialSeed (initialSeed),
      .loadSeed    (loadSeed),
      .random      (random)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
      $fatal(1);
   end

   task automatic edge_sample();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      loadSeed    = 1'b0;
      initialSeed = 32'h0000_0000;
      reset       = 1'b0;
      #1;
      n_cmp++;
      if (random !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL reset_async: random=%08h required=%08h", random, 32'h0000_0000);
      end
      for (int i = 0; i < 2; i++) begin
         edge_sample();
         n_cmp++;
         if (random !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL reset_held[%0d]: random=%08h required=%08h", i, random, 32'h0000_0000);
         end
      end
   endtask

   task automatic test_run();
      logic [31:0] exp_seq [4];
      exp_seq[0] = 32'h3C6E_F35F;
      exp_seq[1] = 32'h4750_2932;
      exp_seq[2] = 32'hD1CC_F6E9;
      exp_seq[3] = 32'hAAF9_5334;
      @(negedge clock);
      reset       = 1'b1;
      initialSeed = 32'hA5A5_5A5A;
      for (int i = 0; i < 4; i++) begin
         edge_sample();
         n_cmp++;
         if (random !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL run_step[%0d]: random=%08h required=%08h", i, random, exp_seq[i]);
         end
      end
   endtask

   task automatic test_reseed();
      @(negedge clock);
      initialSeed = 32'h0000_0001;
      loadSeed    = 1'b1;
      edge_sample();
      n_cmp++;
      if (random !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL reseed_load: random=%08h required=%08h", random, 32'h0000_0001);
      end
      @(negedge clock);
      loadSeed = 1'b0;
      edge_sample();
      n_cmp++;
      if (random !== 32'h3C88_596C) begin
         n_fail++;
         $display("FAIL reseed_step: random=%08h required=%08h", random, 32'h3C88_596C);
      end
   endtask

   task automatic test_wrap();
      @(negedge clock);
      initialSeed = 32'hFFFF_FFFF;
      loadSeed    = 1'b1;
      edge_sample();
      n_cmp++;
      if (random !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_load: random=%08h required=%08h", random, 32'hFFFF_FFFF);
      end
      @(negedge clock);
      loadSeed = 1'b0;
      edge_sample();
      n_cmp++;
      if (random !== 32'h3C55_8D52) begin
         n_fail++;
         $display("FAIL wrap_step: random=%08h required=%08h", random, 32'h3C55_8D52);
      end
   endtask

   task automatic test_load_hold();
      @(negedge clock);
      initialSeed = 32'h1234_5678;
      loadSeed    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         edge_sample();
         n_cmp++;
         if (random !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL load_hold[%0d]: random=%08h required=%08h", i, random, 32'h1234_5678);
         end
      end
      @(negedge clock);
      initialSeed = 32'hCAFE_F00D;
      edge_sample();
      n_cmp++;
      if (random !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL load_track: random=%08h required=%08h", random, 32'hCAFE_F00D);
      end
      @(negedge clock);
      loadSeed = 1'b0;
   endtask

   task automatic test_async_reset();
      edge_sample();
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (random !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL async_mid_run: random=%08h required=%08h", random, 32'h0000_0000);
      end
      @(negedge clock);
      reset = 1'b1;
      edge_sample();
      n_cmp++;
      if (random !== 32'h3C6E_F35F) begin
         n_fail++;
         $display("FAIL async_release_step: random=%08h required=%08h", random, 32'h3C6E_F35F);
      end
   endtask

   task automatic test_priority();
      edge_sample();
      @(negedge clock);
      reset       = 1'b0;
      loadSeed    = 1'b1;
      initialSeed = 32'hDEAD_BEEF;
      edge_sample();
      n_cmp++;
      if (random !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL priority_reset_over_load: random=%08h required=%08h", random, 32'h0000_0000);
      end
      @(negedge clock);
      reset    = 1'b1;
      loadSeed = 1'b0;
      edge_sample();
      n_cmp++;
      if (random !== 32'h3C6E_F35F) begin
         n_fail++;
         $display("FAIL priority_release_step: random=%08h required=%08h", random, 32'h3C6E_F35F);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_reseed();
      test_wrap();
      test_load_hold();
      test_async_reset();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_linear_rng_gen
